// File: rtl/countdown_dec_pkg.sv
// Shared BCD counter definitions used by the down counter and its up-counting sibling.
// Digit width, largest legal digit, default wrap value and small BCD helpers.
package countdown_dec_pkg;

   localparam int         BCD_W            = 4;
   localparam logic [3:0] BCD_MAX_DIGIT    = 4'h9;
   localparam logic [7:0] MAXCOUNT_DEFAULT = 8'h59;

   // Operation selected for the current edge, after priority resolution.
   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_DEC   = 2'd1,
      OP_LOAD  = 2'd2,
      OP_RESET = 2'd3
   } op_e;

   function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] d);
      return d <= BCD_MAX_DIGIT;
   endfunction

   function automatic logic bcd_pair_ok(input logic [2*BCD_W-1:0] v);
      return bcd_digit_ok(v[2*BCD_W-1:BCD_W]) && bcd_digit_ok(v[BCD_W-1:0]);
   endfunction

endpackage

// File: rtl/countdown_dec_digit.sv
// One BCD digit of a down counter: decrements on borrow-in, wraps from 0 to the
// supplied wrap digit and propagates the borrow onward when it does.
module bcd_digit_down
   import countdown_dec_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic [BCD_W-1:0] wrap,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] next_digit,
   output logic             borrow_out
);

   always_comb begin
      next_digit = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == '0) begin
            next_digit = wrap;
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 1'b1;
         end
      end
   end

endmodule

// File: rtl/countdown_dec.sv
// Two-digit BCD down counter with preset, ripple borrow out and done/error pulses.
// Define COUNTDOWN_DEC_HOLD_AT_ZERO_EN to saturate at 00 instead of wrapping to MAXCOUNT.
module countdown_dec
   import countdown_dec_pkg::*;
#(
   parameter logic [7:0] MAXCOUNT = MAXCOUNT_DEFAULT
)
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Enable,
   input  logic       Load,
   input  logic [7:0] LoadValue,
   output logic [7:0] CurrentCount,
   output logic       RBO,
   output logic       Done,
   output logic       LoadErr
);

   logic [7:0]       count_q;
   logic [7:0]       count_d;
   logic             done_q;
   logic             done_d;
   logic             err_q;
   logic             err_d;
   op_e              op;
   logic             load_ok;
   logic [BCD_W-1:0] units_next;
   logic [BCD_W-1:0] tens_next;
   logic             units_borrow;
   logic             underflow;
   logic [7:0]       dec_value;

   // The units digit always sees a borrow; whether it is used depends on op.
   bcd_digit_down u_units (
      .digit      (count_q[3:0]),
      .wrap       (MAXCOUNT[3:0]),
      .borrow_in  (1'b1),
      .next_digit (units_next),
      .borrow_out (units_borrow)
   );

   bcd_digit_down u_tens (
      .digit      (count_q[7:4]),
      .wrap       (MAXCOUNT[7:4]),
      .borrow_in  (units_borrow),
      .next_digit (tens_next),
      .borrow_out (underflow)
   );

   assign dec_value = {tens_next, units_next};
   assign load_ok   = bcd_pair_ok(LoadValue) && (LoadValue <= MAXCOUNT);

   always_comb begin
      op = OP_IDLE;
      if (Reset) begin
         op = OP_RESET;
      end else if (Load) begin
         op = OP_LOAD;
      end else if (Enable) begin
         op = OP_DEC;
      end
   end

   always_comb begin
      count_d = count_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (op)
         OP_RESET: begin
            count_d = 8'h00;
         end
         OP_LOAD: begin
            if (load_ok) begin
               count_d = LoadValue;
            end else begin
               count_d = MAXCOUNT;
               err_d   = 1'b1;
            end
         end
         OP_DEC: begin
            // A borrow out of the tens digit means the count was already 00.
            if (underflow) begin
`ifdef COUNTDOWN_DEC_HOLD_AT_ZERO_EN
               count_d = count_q;
`else
               count_d = dec_value;
`endif
            end else begin
               count_d = dec_value;
               done_d  = (dec_value == 8'h00);
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= 8'h00;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign CurrentCount = count_q;
   assign Done         = done_q;
   assign LoadErr      = err_q;
   assign RBO          = (count_q == 8'h00);

endmodule

// File: tb/tb_countdown_dec.sv
// Self-checking bench for countdown_dec: a default-width instance (MAXCOUNT 59) and a
// MAXCOUNT 23 instance, with a reference model feeding an expected-results queue.
module tb_countdown_dec;

   logic       clk;
   logic       rst_a, en_a, ld_a;
   logic [7:0] lv_a;
   logic [7:0] cnt_a;
   logic       rbo_a, done_a, err_a;
   logic       rst_b, en_b, ld_b;
   logic [7:0] lv_b;
   logic [7:0] cnt_b;
   logic       rbo_b, done_b, err_b;

   int checks   = 0;
   int failures = 0;

   // Packed expectation: {count[7:0], done, loaderr}
   logic [9:0] exp_q[$];
   logic [7:0] m_count[2];

   countdown_dec u_dut_a (
      .Clk(clk), .Reset(rst_a), .Enable(en_a), .Load(ld_a), .LoadValue(lv_a),
      .CurrentCount(cnt_a), .RBO(rbo_a), .Done(done_a), .LoadErr(err_a)
   );

   countdown_dec #(.MAXCOUNT(8'h23)) u_dut_b (
      .Clk(clk), .Reset(rst_b), .Enable(en_b), .Load(ld_b), .LoadValue(lv_b),
      .CurrentCount(cnt_b), .RBO(rbo_b), .Done(done_b), .LoadErr(err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] model(input logic [7:0] c, input logic [7:0] mx,
                                        input logic rst, input logic ld,
                                        input logic [7:0] lv, input logic en);
      logic [7:0] n;
      if (rst) return {8'h00, 2'b00};
      if (ld) begin
         if (lv[7:4] > 4'd9 || lv[3:0] > 4'd9 || lv > mx) return {mx, 2'b01};
         return {lv, 2'b00};
      end
      if (en) begin
         if (c == 8'h00) begin
`ifdef COUNTDOWN_DEC_HOLD_AT_ZERO_EN
            return {8'h00, 2'b00};
`else
            return {mx, 2'b00};
`endif
         end
         if (c[3:0] != 4'd0) n = {c[7:4], c[3:0] - 4'd1};
         else                n = {c[7:4] - 4'd1, mx[3:0]};
         return {n, (n == 8'h00), 1'b0};
      end
      return {c, 2'b00};
   endfunction

   // Drives one cycle on the selected instance, queues the model result, and
   // returns 1 time unit after the sampling edge.
   task automatic drive(input bit sel, input logic rst, input logic ld,
                        input logic [7:0] lv, input logic en);
      logic [9:0] r;
      if (sel == 1'b0) begin
         rst_a = rst; ld_a = ld; lv_a = lv; en_a = en;
      end else begin
         rst_b = rst; ld_b = ld; lv_b = lv; en_b = en;
      end
      r = model(m_count[sel], sel ? 8'h23 : 8'h59, rst, ld, lv, en);
      m_count[sel] = r[9:2];
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      rst_a = 1'b0; ld_a = 1'b0; en_a = 1'b0;
      rst_b = 1'b0; ld_b = 1'b0; en_b = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] e;
      drive(1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e || e !== 10'h000) begin
         failures++;
         $display("FAIL reset_a got=%h exp=%h", {cnt_a, done_a, err_a}, 10'h000);
      end
      checks++;
      if (rbo_a !== 1'b1) begin
         failures++;
         $display("FAIL reset_rbo got=%b exp=1", rbo_a);
      end
      e = exp_q.pop_front();
      checks++;
      if ({cnt_b, done_b, err_b} !== e) begin
         failures++;
         $display("FAIL reset_b got=%h exp=%h", {cnt_b, done_b, err_b}, e);
      end
   endtask

   task automatic test_countdown();
      logic [9:0] e;
      logic [7:0] hand;
      drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (cnt_a !== 8'h10 || cnt_a !== e[9:2] || rbo_a !== 1'b0) begin
         failures++;
         $display("FAIL load_10 got=%h rbo=%b exp=10 rbo=0", cnt_a, rbo_a);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         e = exp_q.pop_front();
         hand = 8'(9 - i);
         checks++;
         if ({cnt_a, done_a, err_a} !== e || cnt_a !== hand || done_a !== (i == 9)) begin
            failures++;
            $display("FAIL countdown step=%0d got=%h done=%b exp=%h done=%b",
                     i, cnt_a, done_a, hand, (i == 9));
         end
         checks++;
         if (rbo_a !== (hand == 8'h00)) begin
            failures++;
            $display("FAIL countdown_rbo step=%0d got=%b exp=%b", i, rbo_a, (hand == 8'h00));
         end
      end
      // Done is a single-cycle pulse.
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e || done_a !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse got=%h exp=%h", {cnt_a, done_a, err_a}, e);
      end
   endtask

   task automatic test_underflow();
      logic [9:0] e;
      logic [7:0] want;
`ifdef COUNTDOWN_DEC_HOLD_AT_ZERO_EN
      want = 8'h00;
`else
      want = 8'h59;
`endif
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e || cnt_a !== want || done_a !== 1'b0) begin
         failures++;
         $display("FAIL underflow got=%h done=%b exp=%h done=0", cnt_a, done_a, want);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e) begin
         failures++;
         $display("FAIL after_underflow got=%h exp=%h", {cnt_a, done_a, err_a}, e);
      end
   endtask

   task automatic test_load_err();
      logic [9:0] e;
      logic [7:0] vals[6];
      logic       bad[6];
      vals = '{8'h4A, 8'h72, 8'h60, 8'h59, 8'hA0, 8'h00};
      bad  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 1'b1, vals[i], 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({cnt_a, done_a, err_a} !== e || err_a !== bad[i] || done_a !== 1'b0 ||
             cnt_a !== (bad[i] ? 8'h59 : vals[i])) begin
            failures++;
            $display("FAIL load val=%h got=%h err=%b done=%b exp=%h err=%b done=0", vals[i],
                     cnt_a, err_a, done_a, bad[i] ? 8'h59 : vals[i], bad[i]);
         end
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if ({cnt_a, done_a, err_a} !== e || err_a !== 1'b0) begin
            failures++;
            $display("FAIL loaderr_pulse val=%h got=%h exp=%h", vals[i], {cnt_a, done_a, err_a}, e);
         end
      end
   endtask

   task automatic test_priority();
      logic [9:0] e;
      drive(1'b0, 1'b0, 1'b1, 8'h30, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b1, 8'h25, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e || cnt_a !== 8'h25) begin
         failures++;
         $display("FAIL load_over_enable got=%h exp=25", cnt_a);
      end
      drive(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_a, done_a, err_a} !== e || cnt_a !== 8'h00 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort got=%h done=%b exp=00 done=0", cnt_a, done_a);
      end
   endtask

   task automatic test_maxcount23();
      logic [9:0] e;
      logic [7:0] want[6];
      logic       dn[6];
`ifdef COUNTDOWN_DEC_HOLD_AT_ZERO_EN
      want = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
`else
      want = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h23, 8'h22};
`endif
      dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      drive(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         e = exp_q.pop_front();
         checks++;
         if ({cnt_b, done_b, err_b} !== e || cnt_b !== want[i] || done_b !== dn[i]) begin
            failures++;
            $display("FAIL max23 step=%0d got=%h done=%b exp=%h done=%b",
                     i, cnt_b, done_b, want[i], dn[i]);
         end
      end
      drive(1'b1, 1'b0, 1'b1, 8'h24, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({cnt_b, done_b, err_b} !== e || cnt_b !== 8'h23 || err_b !== 1'b1) begin
         failures++;
         $display("FAIL max23_load got=%h err=%b exp=23 err=1", cnt_b, err_b);
      end
   endtask

   task automatic test_random();
      logic [9:0] e;
      logic       r, l, n;
      logic [7:0] v;
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 3) == 0);
         n = ($urandom_range(0, 3) != 0);
         v = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) v = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
         drive(1'b0, r, l, v, n);
         e = exp_q.pop_front();
         checks++;
         if ({cnt_a, done_a, err_a} !== e || rbo_a !== (e[9:2] == 8'h00)) begin
            failures++;
            $display("FAIL random i=%0d got=%h rbo=%b exp=%h", i, {cnt_a, done_a, err_a}, rbo_a, e);
         end
      end
   endtask

   initial begin
      rst_a = 1'b0; ld_a = 1'b0; en_a = 1'b0; lv_a = 8'h00;
      rst_b = 1'b0; ld_b = 1'b0; en_b = 1'b0; lv_b = 8'h00;
      m_count[0] = 8'h00;
      m_count[1] = 8'h00;
      test_reset();
      test_countdown();
      test_underflow();
      test_load_err();
      test_priority();
      test_maxcount23();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
